// File: rtl/epochtv1_capture.sv
// epochtv1_capture
// Captures one armed frame from the EPOCH TV-1 video stream, converts each
// pixel to RGB565, queues {address, data} in a small FIFO and writes it to an
// external frame buffer over a REQ/ACK write port.
//
// Ports
//   CLK, RES        core clock, synchronous active-high reset
//   CE, DE, VS, RGB video stream from epochtv1 (pixel valid when CE & DE)
//   ARM             pulse: capture the next frame (only honoured while idle)
//   MEM_REQ/ACK     write handshake; MEM_A/MEM_D show the FIFO head while REQ=1
//   BUSY            capture in progress (state != IDLE)
//   FRAME_DONE      1-cycle pulse once the frame is closed and the FIFO drained
//   OVERFLOW        sticky: a pixel was dropped because the FIFO was full
//   FRAME_CRC       CRC-16/CCITT of all pushed words of the captured frame
//
// Build option
//   EPOCHTV1_CAPTURE_CRC_EN  when defined, FRAME_CRC is computed; otherwise it
//                            is tied to zero and no CRC logic is built.
//
// state    | meaning
// IDLE     | waiting for ARM
// WAIT_VS  | armed, waiting for the start of the next frame (VS rise)
// ACTIVE   | capturing pixels of the frame
// DRAIN    | frame closed, emptying the FIFO to the frame buffer

module epochtv1_capture #(
    parameter int MAX_W      = 256,
    parameter int MAX_H      = 256,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              CE,
    input  logic              DE,
    input  logic              VS,
    input  logic [23:0]       RGB,
    input  logic              ARM,
    output logic              MEM_REQ,
    input  logic              MEM_ACK,
    output logic [ADDR_W-1:0] MEM_A,
    output logic [15:0]       MEM_D,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              OVERFLOW,
    output logic [15:0]       FRAME_CRC
);

    localparam int XB = $clog2(MAX_W);
    localparam int LB = $clog2(MAX_H);
    localparam int PB = $clog2(FIFO_DEPTH);
    localparam int EW = ADDR_W + 16;

    // Counters carry one extra bit so they can reach MAX_W / MAX_H / DEPTH.
    localparam logic [XB:0] X_LIM = MAX_W[XB:0];
    localparam logic [LB:0] L_LIM = MAX_H[LB:0];
    localparam logic [PB:0] F_LIM = FIFO_DEPTH[PB:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic          vs_q;
    logic          de_q;
    logic [XB:0]   x_q;
    logic [LB:0]   line_q;
    logic          ovf_q;
    logic          done_q;
    logic          done_d;
    logic [PB:0]   count_q;
    logic [PB-1:0] wr_ptr_q;
    logic [PB-1:0] rd_ptr_q;
    logic [EW-1:0] fifo_q [FIFO_DEPTH];

    logic              vs_rise;
    logic              enter_active;
    logic              fifo_empty;
    logic              pix_acc;
    logic              line_end;
    logic              push;
    logic              pop;
    logic              drop;
    logic [ADDR_W-1:0] push_addr;
    logic [15:0]       push_data;
    logic [EW-1:0]     head;

    assign vs_rise    = VS & ~vs_q;
    assign fifo_empty = (count_q == '0);
    assign pop        = ~fifo_empty & MEM_ACK;

    assign pix_acc  = CE & DE & (state_q == S_ACTIVE) & (x_q < X_LIM) & (line_q < L_LIM);
    assign line_end = CE & de_q & ~DE & (state_q == S_ACTIVE);

    // A full FIFO still accepts a pixel when the head leaves in the same cycle.
    assign push = pix_acc & ((count_q != F_LIM) | pop);
    assign drop = pix_acc & ~push;

    // MAX_W and MAX_H are powers of two, so line*MAX_W + x is a concatenation.
    assign push_addr = ADDR_W'({line_q[LB-1:0], x_q[XB-1:0]});
    assign push_data = {RGB[23:19], RGB[15:10], RGB[7:3]};

    assign head       = fifo_q[rd_ptr_q];
    assign MEM_REQ    = ~fifo_empty;
    assign MEM_A      = MEM_REQ ? head[EW-1:16] : '0;
    assign MEM_D      = MEM_REQ ? head[15:0]    : '0;
    assign BUSY       = (state_q != S_IDLE);
    assign FRAME_DONE = done_q;
    assign OVERFLOW   = ovf_q;

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        enter_active = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ARM) state_d = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (vs_rise) begin
                    state_d      = S_ACTIVE;
                    enter_active = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (vs_rise) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q  <= S_IDLE;
            vs_q     <= 1'b0;
            de_q     <= 1'b0;
            x_q      <= '0;
            line_q   <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= VS;
            done_q  <= done_d;
            if (CE) de_q <= DE;

            if (enter_active) begin
                x_q    <= '0;
                line_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (pix_acc) x_q <= x_q + 1'b1;
                if (line_end) begin
                    x_q <= '0;
                    if (line_q < L_LIM) line_q <= line_q + 1'b1;
                end
                if (drop) ovf_q <= 1'b1;
            end

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count_q says so.
    always_ff @(posedge CLK) begin
        if (push) fifo_q[wr_ptr_q] <= {push_addr, push_data};
    end

`ifdef EPOCHTV1_CAPTURE_CRC_EN
    logic [15:0] crc_q;

    // CRC-16/CCITT, poly 0x1021, MSB first, one 16-bit word per call.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                               input logic [15:0] word);
        logic [15:0] c;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ word[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_ff @(posedge CLK) begin
        if (RES)               crc_q <= '0;
        else if (enter_active) crc_q <= 16'hFFFF;
        else if (push)         crc_q <= crc16_step(crc_q, push_data);
    end

    assign FRAME_CRC = crc_q;
`else
    assign FRAME_CRC = 16'h0000;
`endif

endmodule
